sample_tick_gen: RTL and testbench
==================================

# sample_tick_gen

Consumer of the 7-bit prescaler value produced by the switch-mode prescaler: converts the selected division ratio into a periodic single-cycle SAMPLE_TICK enable that paces the acquisition front end. Supports continuous or fixed-length (burst) sampling, start/stop control, and glitch-free adoption of a new prescaler value only on a period boundary. Sits between the mode selector and the ADC capture / sample FIFO logic, all in the SYS_CLK domain.

## Interface
- CNT_W, 7, width of prescaler_value and the internal period counter
- BURST_W, 16, width of burst_len and tick_count
- SYS_CLK  in  1  system clock, all logic on rising edge
- RESET_N  in  1  synchronous, active-low reset
- prescaler_value  in  CNT_W  requested period in SYS_CLK cycles; 0 treated as 1
- START  in  1  level sampled each edge; begins a run when IDLE
- STOP  in  1  level sampled each edge; aborts a run
- burst_len  in  BURST_W  ticks per run, latched at START; 0 = continuous
- SAMPLE_TICK  out  1  one-cycle sample enable, registered
- BUSY  out  1  high while in RUN, registered
- DONE  out  1  one-cycle pulse on burst completion, registered
- tick_count  out  BURST_W  ticks issued in current/last run
- active_prescale  out  CNT_W  period currently in force

## Operation
- Reset (RESET_N low at an edge): state IDLE, SAMPLE_TICK=0, BUSY=0, DONE=0, tick_count=0, active_prescale=1, counter=0, burst latch=0.
- States: IDLE, RUN. No other states.
- IDLE -> RUN: START=1 and STOP=0 at an edge. Same edge: counter<=0, tick_count<=0, active_prescale<=max(prescaler_value,1), burst latch<=burst_len, BUSY<=1.
- START=1 with STOP=1 in IDLE: stay IDLE. START while RUN: ignored.
- RUN, each edge with STOP=0: if counter==active_prescale-1 (boundary): counter<=0, SAMPLE_TICK<=1, tick_count<=tick_count+1, active_prescale<=max(prescaler_value,1); else counter<=counter+1, SAMPLE_TICK<=0.
- Burst end: at a boundary edge where tick_count+1 == burst latch (latch nonzero): SAMPLE_TICK<=1, DONE<=1, BUSY<=0, state IDLE. Final tick and DONE are coincident.
- Continuous (latch 0): tick_count wraps 2^BURST_W-1 -> 0; no DONE.
- STOP=1 in RUN: next edge -> IDLE, BUSY<=0, SAMPLE_TICK<=0 even if at boundary, no DONE, tick_count holds.
- prescaler_value changes mid-period: no effect until the next boundary; current period completes at the old length.
- DONE and SAMPLE_TICK low in every cycle not explicitly set above.
- tick_count and active_prescale hold in IDLE.

## Timing
- START sampled at edge k with period P: first SAMPLE_TICK high in the cycle after edge k+P; subsequent ticks every P cycles.
- P=1: SAMPLE_TICK high every cycle from edge k+1.
- New prescaler value adopted at boundary edge b: next tick at edge b+P_new.
- BUSY rises in cycle after START edge; falls coincident with DONE or one cycle after STOP sampled.
- Reset synchronous: takes effect at the first edge with RESET_N low, overriding all other inputs, including mid-run.
- Back-to-back runs: START sampled the edge after DONE restarts normally (one IDLE cycle minimum).

## Structure
- Shared package: CNT_W/BURST_W defaults, state encoding (IDLE, RUN), constant MIN_PRESCALE=1.
- Optional sub-module period_counter (counter, boundary detect, reload with zero-clamp); FSM, burst logic and outputs in top.

## Test plan
- Reset then prescaler_value=5, burst_len=3, START pulse at edge k -> SAMPLE_TICK at edges k+5, k+10, k+15; DONE with third tick; BUSY low after; tick_count=3.
- prescaler_value=0, burst_len=4 -> treated as 1: ticks on 4 consecutive cycles from k+1, active_prescale=1, DONE on 4th.
- Continuous, prescaler 10, change to 20 at cycle k+13 -> ticks at k+10, k+20, k+40; active_prescale becomes 20 at edge k+20.
- Continuous, prescaler 25, STOP asserted at boundary edge of 2nd tick -> only one tick, no DONE, tick_count=1, BUSY low.
- START and STOP both high in IDLE -> stays IDLE, no ticks; START during RUN -> no restart, tick cadence unchanged.
- RESET_N low mid-run with prescaler 100 -> next edge all outputs at reset values, active_prescale=1; continuous run at prescaler 1 for 65537 cycles -> tick_count wraps to 1.

Source files
------------

// File: rtl/sample_tick_gen_pkg.sv
// Shared constants, state encoding and prescale clamp for sample_tick_gen.
// Imported by the interface, the period counter and the top.
package sample_tick_gen_pkg;
    localparam int CNT_W        = 7;
    localparam int BURST_W      = 16;
    localparam int MIN_PRESCALE = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic logic [CNT_W-1:0] clamp_prescale(
        input logic [CNT_W-1:0] v
    );
        return (v == '0) ? CNT_W'(MIN_PRESCALE) : v;
    endfunction
endpackage

// File: rtl/sample_tick_gen_if.sv
// Control and status bundle between the mode selector / capture logic
// and sample_tick_gen.
interface sample_tick_gen_if;
    import sample_tick_gen_pkg::*;

    logic [CNT_W-1:0]   prescaler_value;
    logic               START;
    logic               STOP;
    logic [BURST_W-1:0] burst_len;
    logic               SAMPLE_TICK;
    logic               BUSY;
    logic               DONE;
    logic [BURST_W-1:0] tick_count;
    logic [CNT_W-1:0]   active_prescale;

    modport master (
        output prescaler_value, START, STOP, burst_len,
        input  SAMPLE_TICK, BUSY, DONE, tick_count, active_prescale
    );

    modport slave (
        input  prescaler_value, START, STOP, burst_len,
        output SAMPLE_TICK, BUSY, DONE, tick_count, active_prescale
    );
endinterface

// File: rtl/sample_tick_gen_period_counter.sv
// Period counter: counts SYS_CLK cycles within one sample period and
// reloads the active prescale (zero clamped to one) only at a boundary.
module sample_tick_gen_period_counter
    import sample_tick_gen_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             advance,
    input  logic [CNT_W-1:0] prescaler_value,
    output logic             boundary,
    output logic [CNT_W-1:0] active_prescale
);
    logic [CNT_W-1:0] counter_q, counter_d;
    logic [CNT_W-1:0] active_q, active_d;

    assign boundary        = (counter_q == active_q - CNT_W'(1));
    assign active_prescale = active_q;

    always_comb begin
        counter_d = counter_q;
        active_d  = active_q;
        if (load) begin
            counter_d = '0;
            active_d  = clamp_prescale(prescaler_value);
        end else if (advance) begin
            if (boundary) begin
                counter_d = '0;
                active_d  = clamp_prescale(prescaler_value);
            end else begin
                counter_d = counter_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            counter_q <= '0;
            active_q  <= CNT_W'(MIN_PRESCALE);
        end else begin
            counter_q <= counter_d;
            active_q  <= active_d;
        end
    end
endmodule

// File: rtl/sample_tick_gen.sv
// Sample tick generator: paces acquisition with a one-cycle SAMPLE_TICK
// every active_prescale cycles, continuous or for a fixed burst.
module sample_tick_gen
    import sample_tick_gen_pkg::*;
(
    input  logic             SYS_CLK,
    input  logic             RESET_N,
    sample_tick_gen_if.slave bus
);
    state_e             state_q, state_d;
    logic               tick_q, tick_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [BURST_W-1:0] tick_count_q, tick_count_d;
    logic [BURST_W-1:0] burst_q, burst_d;

    logic               start_go;
    logic               run_adv;
    logic               boundary;
    logic [BURST_W-1:0] tick_next;

    assign start_go  = (state_q == IDLE) && bus.START && !bus.STOP;
    assign run_adv   = (state_q == RUN) && !bus.STOP;
    assign tick_next = tick_count_q + BURST_W'(1);

    sample_tick_gen_period_counter u_period (
        .clk             (SYS_CLK),
        .rst_n           (RESET_N),
        .load            (start_go),
        .advance         (run_adv),
        .prescaler_value (bus.prescaler_value),
        .boundary        (boundary),
        .active_prescale (bus.active_prescale)
    );

    always_comb begin
        state_d      = state_q;
        tick_d       = 1'b0;
        done_d       = 1'b0;
        busy_d       = busy_q;
        tick_count_d = tick_count_q;
        burst_d      = burst_q;
        unique case (state_q)
            IDLE: begin
                if (start_go) begin
                    state_d      = RUN;
                    busy_d       = 1'b1;
                    tick_count_d = '0;
                    burst_d      = bus.burst_len;
                end
            end
            RUN: begin
                if (bus.STOP) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (boundary) begin
                    tick_d       = 1'b1;
                    tick_count_d = tick_next;
                    // Last tick of a burst and DONE land on the same edge
                    if (burst_q != '0 && tick_next == burst_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge SYS_CLK) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            tick_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            tick_count_q <= '0;
            burst_q      <= '0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            tick_count_q <= tick_count_d;
            burst_q      <= burst_d;
        end
    end

    assign bus.SAMPLE_TICK = tick_q;
    assign bus.BUSY        = busy_q;
    assign bus.DONE        = done_q;
    assign bus.tick_count  = tick_count_q;
endmodule

// File: tb/tb_sample_tick_gen.sv
// Scoreboard bench for sample_tick_gen against an absolute-time model
// of tick instants, bursts, stops and resets.
module tb_sample_tick_gen;
    import sample_tick_gen_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sample_tick_gen_if bus();

    sample_tick_gen dut (
        .SYS_CLK (clk),
        .RESET_N (rst_n),
        .bus     (bus.slave)
    );

    typedef struct {
        int unsigned edge_n;
        int unsigned tc;
        bit          done;
        int unsigned act;
    } ev_t;

    ev_t exp_q[$];
    int total = 0;
    int bad = 0;
    int unsigned edge_n = 0;

    // Model: run flag, absolute edge of next tick, ticks, burst, period
    bit          m_run = 1'b0;
    int unsigned m_next = 0;
    int unsigned m_ticks = 0;
    int unsigned m_burst = 0;
    int unsigned m_act = 1;

    int cur_pv = 1;
    int cur_bl = 0;

    function automatic int unsigned clampv(input int pv);
        return (pv % 128 == 0) ? 1 : pv % 128;
    endfunction

    task automatic chk(input string name, input int unsigned act,
                       input int unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s edge=%0d got=%0d want=%0d",
                     name, edge_n, act, exp);
        end
    endtask

    task automatic step(input bit rs, input bit st, input bit sp);
        int unsigned e;
        ev_t ev;
        rst_n = rs;
        bus.START = st;
        bus.STOP = sp;
        bus.prescaler_value = CNT_W'(cur_pv);
        bus.burst_len = BURST_W'(cur_bl);
        e = edge_n + 1;
        if (!rs) begin
            m_run = 1'b0;
            m_ticks = 0;
            m_act = 1;
        end else if (!m_run) begin
            if (st && !sp) begin
                m_run = 1'b1;
                m_ticks = 0;
                m_act = clampv(cur_pv);
                m_burst = cur_bl % 65536;
                m_next = e + m_act;
            end
        end else if (sp) begin
            m_run = 1'b0;
        end else if (e == m_next) begin
            m_ticks = (m_ticks + 1) % 65536;
            m_act = clampv(cur_pv);
            m_next = e + m_act;
            ev.edge_n = e;
            ev.tc = m_ticks;
            ev.done = (m_burst != 0) && (m_ticks == m_burst);
            ev.act = m_act;
            if (ev.done) m_run = 1'b0;
            exp_q.push_back(ev);
        end
        @(posedge clk);
        #1;
        edge_n = e;
        chk("busy", 32'(bus.BUSY), 32'(m_run));
        chk("tick_count", 32'(bus.tick_count), m_ticks);
        chk("active_prescale", 32'(bus.active_prescale), m_act);
    endtask

    task automatic idle(input int n, input bit st = 1'b0);
        for (int i = 0; i < n; i++) step(1'b1, st, 1'b0);
    endtask

    // Monitor: every presented tick/done must match the next expected event
    always @(negedge clk) begin
        ev_t ev;
        if (bus.SAMPLE_TICK === 1'b1 || bus.DONE === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_tick edge=%0d tick=%b done=%b",
                         edge_n, bus.SAMPLE_TICK, bus.DONE);
            end else begin
                ev = exp_q.pop_front();
                if (ev.edge_n != edge_n || bus.SAMPLE_TICK !== 1'b1 ||
                    bus.DONE !== ev.done ||
                    32'(bus.tick_count) != ev.tc ||
                    32'(bus.active_prescale) != ev.act) begin
                    bad++;
                    $display("FAIL tick_event got edge=%0d done=%b tc=%0d act=%0d want edge=%0d done=%b tc=%0d act=%0d",
                             edge_n, bus.DONE, bus.tick_count,
                             bus.active_prescale, ev.edge_n, ev.done,
                             ev.tc, ev.act);
                end
            end
        end
    end

    initial begin
        bus.START = 1'b0;
        bus.STOP = 1'b0;
        bus.prescaler_value = '0;
        bus.burst_len = '0;

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        idle(2);

        // Burst of 3 at period 5
        cur_pv = 5; cur_bl = 3;
        step(1'b1, 1'b1, 1'b0);
        idle(20);

        // Zero prescale clamps to one
        cur_pv = 0; cur_bl = 4;
        step(1'b1, 1'b1, 1'b0);
        idle(8);

        // Continuous, period change mid-period
        cur_pv = 10; cur_bl = 0;
        step(1'b1, 1'b1, 1'b0);
        idle(12);
        cur_pv = 20;
        idle(35);
        step(1'b1, 1'b0, 1'b1);
        idle(2);

        // STOP sampled on the second boundary
        cur_pv = 25; cur_bl = 0;
        step(1'b1, 1'b1, 1'b0);
        idle(49);
        step(1'b1, 1'b0, 1'b1);
        idle(30);

        // START with STOP in IDLE, then START held during a run
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1);
        cur_pv = 7; cur_bl = 5;
        step(1'b1, 1'b1, 1'b0);
        idle(10);
        idle(10, 1'b1);
        idle(20);

        // Reset mid-run
        cur_pv = 100; cur_bl = 0;
        step(1'b1, 1'b1, 1'b0);
        idle(30);
        step(1'b0, 1'b1, 1'b0);
        idle(3);

        // Back-to-back bursts with START held
        cur_pv = 3; cur_bl = 2;
        idle(25, 1'b1);
        idle(5);

        // Random mix
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 15) == 0) cur_pv = $urandom_range(0, 9);
            if ($urandom_range(0, 7) == 0) cur_bl = $urandom_range(0, 5);
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 24) == 0);
        end
        idle(20);

        // Continuous at period 1 through tick_count wrap
        cur_pv = 1; cur_bl = 0;
        step(1'b1, 1'b1, 1'b0);
        idle(65537);
        step(1'b1, 1'b0, 1'b1);
        idle(3);

        chk("pending_events", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
